// File: rtl/view_scroller.sv
// view_scroller: tracks the camera window over world space (Y grows upward).
//   - view_bottom follows the doodle once it rises past the scroll line
//     (view_bottom + SCROLL_MARGIN). The view advances at most MAX_STEP per
//     frame tick, so a large jump is caught up over several frames.
//   - A doodle below view_bottom ends the game. score is the highest
//     view_bottom reached, saturated to SCORE_WIDTH bits.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   frame_tick        one-cycle pulse per frame
//   start             starts/restarts a game; wins over a same-cycle tick
//   doodle_valid      doodle_y is valid this cycle
//   doodle_y          signed doodle world Y
//   view_bottom       registered world Y of the bottom screen row
//   view_top          view_bottom + SCREEN_HEIGHT - 1
//   scroll_delta      advance applied on the last update, 0 otherwise
//   new_view          one-cycle pulse when view_bottom changed
//   fell              one-cycle pulse on fall detection
//   game_over         high while the game is over
//   score             saturating max height
//   busy_scroll       high while catching up after a jump
module view_scroller #(
  parameter int WIDTH         = 32,
  parameter int SCREEN_HEIGHT = 700,
  parameter int SCROLL_MARGIN = 350,
  parameter int MAX_STEP      = 4,
  parameter int SCORE_WIDTH   = 24
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               frame_tick,
  input  logic                               start,
  input  logic                               doodle_valid,
  input  logic [WIDTH-1:0]                   doodle_y,
  output logic [WIDTH-1:0]                   view_bottom,
  output logic [WIDTH-1:0]                   view_top,
  output logic [$clog2(MAX_STEP+1)-1:0]      scroll_delta,
  output logic                               new_view,
  output logic                               fell,
  output logic                               game_over,
  output logic [SCORE_WIDTH-1:0]             score,
  output logic                               busy_scroll
);

  localparam int DW = $clog2(MAX_STEP + 1);
  // Two guard bits: enough for sign plus view_bottom + SCROLL_MARGIN.
  localparam int EW = WIDTH + 2;
  localparam int XW = (WIDTH > SCORE_WIDTH) ? WIDTH : SCORE_WIDTH;

  localparam logic [WIDTH-1:0]      VIEW_MAX  = WIDTH'((64'd1 << (WIDTH - 1)) - 64'(SCREEN_HEIGHT));
  localparam logic [WIDTH-1:0]      TOP_OFS   = WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic signed [EW-1:0]  MARGIN_S  = EW'(SCROLL_MARGIN);
  localparam logic signed [EW-1:0]  STEP_S    = EW'(MAX_STEP);
  localparam logic signed [EW-1:0]  ZERO_S    = '0;
  localparam logic [XW-1:0]         SCORE_MAX = XW'({SCORE_WIDTH{1'b1}});

  typedef enum logic [1:0] {IDLE, TRACK, SCROLL, OVER} state_t;

  state_t state, state_next;

  logic signed [EW-1:0] dy_s, vb_s, gap;
  logic                 fall, gap_pos, gap_big, upd;
  logic [DW-1:0]        step_raw, step;
  logic [WIDTH-1:0]     headroom, vb_adv;
  logic [XW-1:0]        vb_adv_x;
  logic [SCORE_WIDTH-1:0] score_adv;

  logic [WIDTH-1:0]       vb_next;
  logic [SCORE_WIDTH-1:0] score_next;
  logic [DW-1:0]          delta_next;
  logic                   nv_next, fell_next;

  // Candidate update arithmetic.
  always_comb begin
    dy_s     = {{2{doodle_y[WIDTH-1]}}, doodle_y};
    vb_s     = {2'b00, view_bottom};
    gap      = dy_s - vb_s - MARGIN_S;
    fall     = dy_s < vb_s;
    gap_pos  = gap > ZERO_S;
    gap_big  = gap > STEP_S;
    step_raw = gap_big ? DW'(MAX_STEP) : DW'(gap);
    // Clip the step so view_bottom never passes VIEW_MAX.
    headroom = VIEW_MAX - view_bottom;
    step     = (WIDTH'(step_raw) > headroom) ? DW'(headroom) : step_raw;
    vb_adv   = view_bottom + WIDTH'(step);
    vb_adv_x = XW'(vb_adv);
    score_adv = (vb_adv_x > SCORE_MAX) ? '1 : SCORE_WIDTH'(vb_adv_x);
    upd      = frame_tick && doodle_valid && !start &&
               ((state == TRACK) || (state == SCROLL));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and next datapath values.
  always_comb begin
    state_next = state;
    vb_next    = view_bottom;
    score_next = score;
    delta_next = '0;
    nv_next    = 1'b0;
    fell_next  = 1'b0;
    if (start) begin
      state_next = TRACK;
      vb_next    = '0;
      score_next = '0;
    end else if (upd) begin
      if (fall) begin
        state_next = OVER;
        fell_next  = 1'b1;
      end else if (gap_pos) begin
        // Stay in SCROLL while more than one step remains, even if the
        // step itself was clipped at VIEW_MAX.
        state_next = gap_big ? SCROLL : TRACK;
        if (step != '0) begin
          vb_next    = vb_adv;
          score_next = score_adv;
          delta_next = step;
          nv_next    = 1'b1;
        end
      end else begin
        state_next = TRACK;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      view_bottom  <= '0;
      score        <= '0;
      scroll_delta <= '0;
      new_view     <= 1'b0;
      fell         <= 1'b0;
    end else begin
      view_bottom  <= vb_next;
      score        <= score_next;
      scroll_delta <= delta_next;
      new_view     <= nv_next;
      fell         <= fell_next;
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy_scroll = (state == SCROLL);
    game_over   = (state == OVER);
    view_top    = view_bottom + TOP_OFS;
  end

endmodule

// File: tb/tb_view_scroller.sv
module tb_view_scroller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        b_start, b_tick, b_valid;
  logic [31:0] b_dy, b_vb, b_top;
  logic [2:0]  b_delta;
  logic        b_nv, b_fell, b_go, b_busy;
  logic [23:0] b_score;

  // Narrow instance for saturation corners
  logic        s_start, s_tick, s_valid;
  logic [11:0] s_dy, s_vb, s_top;
  logic [2:0]  s_delta;
  logic        s_nv, s_fell, s_go, s_busy;
  logic [7:0]  s_score;

  view_scroller u_big (
    .clk(clk), .reset(reset), .frame_tick(b_tick), .start(b_start),
    .doodle_valid(b_valid), .doodle_y(b_dy), .view_bottom(b_vb),
    .view_top(b_top), .scroll_delta(b_delta), .new_view(b_nv),
    .fell(b_fell), .game_over(b_go), .score(b_score), .busy_scroll(b_busy)
  );

  view_scroller #(.WIDTH(12), .SCREEN_HEIGHT(700), .SCROLL_MARGIN(350),
                  .MAX_STEP(4), .SCORE_WIDTH(8)) u_small (
    .clk(clk), .reset(reset), .frame_tick(s_tick), .start(s_start),
    .doodle_valid(s_valid), .doodle_y(s_dy), .view_bottom(s_vb),
    .view_top(s_top), .scroll_delta(s_delta), .new_view(s_nv),
    .fell(s_fell), .game_over(s_go), .score(s_score), .busy_scroll(s_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    int st, tk, va, dy;
    int vb, dl, nv, fl, go, bs, sc;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(int st, int tk, int va, int dy, int vb, int dl,
                              int nv, int fl, int go, int bs, int sc);
    vec_t v;
    v.st = st; v.tk = tk; v.va = va; v.dy = dy;
    v.vb = vb; v.dl = dl; v.nv = nv; v.fl = fl; v.go = go; v.bs = bs; v.sc = sc;
    return v;
  endfunction

  task automatic chk_big(input int idx, input int vb, input int dl, input int nv,
                         input int fl, input int go, input int bs, input int sc);
    chk("view_bottom",  idx, longint'(b_vb),    longint'(vb));
    chk("view_top",     idx, longint'(b_top),   longint'(vb) + 699);
    chk("scroll_delta", idx, longint'(b_delta), longint'(dl));
    chk("new_view",     idx, longint'(b_nv),    longint'(nv));
    chk("fell",         idx, longint'(b_fell),  longint'(fl));
    chk("game_over",    idx, longint'(b_go),    longint'(go));
    chk("busy_scroll",  idx, longint'(b_busy),  longint'(bs));
    chk("score",        idx, longint'(b_score), longint'(sc));
  endtask

  task automatic chk_small(input int idx, input int vb, input int dl, input int nv,
                           input int go, input int bs, input int sc);
    chk("s_view_bottom",  idx, longint'(s_vb),    longint'(vb));
    chk("s_scroll_delta", idx, longint'(s_delta), longint'(dl));
    chk("s_new_view",     idx, longint'(s_nv),    longint'(nv));
    chk("s_game_over",    idx, longint'(s_go),    longint'(go));
    chk("s_busy_scroll",  idx, longint'(s_busy),  longint'(bs));
    chk("s_score",        idx, longint'(s_score), longint'(sc));
  endtask

  initial begin
    //            st tk va   dy    vb dl nv fl go bs sc
    tbl[0]  = mk(1, 0, 0,    0,   0, 0, 0, 0, 0, 0, 0);  // start -> TRACK
    tbl[1]  = mk(0, 1, 1,  100,   0, 0, 0, 0, 0, 0, 0);  // below line
    tbl[2]  = mk(0, 1, 1,  352,   2, 2, 1, 0, 0, 0, 2);  // gap 2
    tbl[3]  = mk(0, 0, 0,  352,   2, 0, 0, 0, 0, 0, 2);  // pulse ends
    tbl[4]  = mk(1, 0, 0,    0,   0, 0, 0, 0, 0, 0, 0);  // restart
    tbl[5]  = mk(0, 1, 1,  370,   4, 4, 1, 0, 0, 1, 4);  // gap 20
    tbl[6]  = mk(0, 1, 1,  370,   8, 4, 1, 0, 0, 1, 8);
    tbl[7]  = mk(0, 1, 1,  370,  12, 4, 1, 0, 0, 1, 12);
    tbl[8]  = mk(0, 1, 1,  370,  16, 4, 1, 0, 0, 1, 16);
    tbl[9]  = mk(0, 1, 1,  370,  20, 4, 1, 0, 0, 0, 20); // gap 4 exactly
    tbl[10] = mk(0, 1, 1,  370,  20, 0, 0, 0, 0, 0, 20); // on the line
    tbl[11] = mk(0, 1, 1,   19,  20, 0, 0, 1, 1, 0, 20); // fall
    tbl[12] = mk(0, 0, 0,   19,  20, 0, 0, 0, 1, 0, 20);
    tbl[13] = mk(0, 1, 1, 1000,  20, 0, 0, 0, 1, 0, 20); // ignored in OVER
    tbl[14] = mk(1, 0, 0,    0,   0, 0, 0, 0, 0, 0, 0);  // restart from OVER
    tbl[15] = mk(1, 1, 1, 1000,   0, 0, 0, 0, 0, 0, 0);  // start beats tick
    tbl[16] = mk(0, 1, 0, 1000,   0, 0, 0, 0, 0, 0, 0);  // tick without valid
    tbl[17] = mk(0, 1, 1,  350,   0, 0, 0, 0, 0, 0, 0);  // exact scroll line
    tbl[18] = mk(0, 1, 1,    0,   0, 0, 0, 0, 0, 0, 0);  // equal: no fall
    tbl[19] = mk(0, 1, 1,   -5,   0, 0, 0, 1, 1, 0, 0);  // negative: fall
    tbl[20] = mk(1, 0, 0,    0,   0, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 1, 1,  355,   4, 4, 1, 0, 0, 1, 4);  // gap 5 -> SCROLL
    tbl[22] = mk(0, 1, 0,  355,   4, 0, 0, 0, 0, 1, 4);  // invalid tick holds

    reset = 1'b1;
    b_start = 0; b_tick = 0; b_valid = 0; b_dy = '0;
    s_start = 0; s_tick = 0; s_valid = 0; s_dy = '0;

    #12;
    chk_big(-1, 0, 0, 0, 0, 0, 0, 0);
    chk_small(-1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      b_start = (tbl[i].st != 0);
      b_tick  = (tbl[i].tk != 0);
      b_valid = (tbl[i].va != 0);
      b_dy    = tbl[i].dy;
      @(posedge clk);
      #1;
      chk_big(i, tbl[i].vb, tbl[i].dl, tbl[i].nv, tbl[i].fl, tbl[i].go,
              tbl[i].bs, tbl[i].sc);
    end
    @(negedge clk);
    b_start = 0; b_tick = 0; b_valid = 0;

    // Narrow instance: drive up to VIEW_MAX = 2048 - 700 = 1348.
    s_start = 1;
    @(negedge clk);
    s_start = 0; s_tick = 1; s_valid = 1; s_dy = 12'h7FF;
    for (int k = 1; k <= 336; k++) begin
      @(posedge clk);
      #1;
      if (k == 63) chk("s_score_252", k, longint'(s_score), 252);
      if (k == 64) chk("s_score_sat", k, longint'(s_score), 255);
    end
    chk_small(100, 1344, 4, 1, 0, 1, 255);

    @(negedge clk);
    s_dy = 12'd1696;                       // gap 2
    @(posedge clk); #1;
    chk_small(101, 1346, 2, 1, 0, 0, 255);

    @(negedge clk);
    s_dy = 12'h7FF;                        // gap 351, clipped to 2
    @(posedge clk); #1;
    chk_small(102, 1348, 2, 1, 0, 1, 255);
    chk("s_view_top", 102, longint'(s_top), 2047);

    @(negedge clk);                        // clipped step is 0
    @(posedge clk); #1;
    chk_small(103, 1348, 0, 0, 0, 1, 255);

    // Asynchronous reset while both instances are in SCROLL.
    @(negedge clk);
    s_tick = 0; s_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk_big(200, 0, 0, 0, 0, 0, 0, 0);
    chk_small(200, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    s_tick = 1; s_valid = 1;               // IDLE ignores ticks
    @(posedge clk); #1;
    chk_small(201, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    s_tick = 0; s_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/view_scroller.md
Name: view_scroller

Overview:
- Clocked, parametrised successor to the combinational view/scroll logic in the game datapath.
- Tracks the camera window over world space: view_bottom advances when the doodle rises past a scroll line, by at most MAX_STEP per frame tick, spreading large jumps over several frames.
- Detects the doodle falling below the view (game over) and maintains a saturating height score.
- Sits between the physics block (supplies doodle_y) and the platform generator / renderer (consume view_bottom, scroll_delta, new_view).
- World Y increases upward.

Parameters:
WIDTH, 32, bit width of world coordinates (doodle_y signed, view_bottom unsigned)
SCREEN_HEIGHT, 700, visible window height in world units
SCROLL_MARGIN, 350, scroll line offset above view_bottom
MAX_STEP, 4, maximum view advance per frame tick (must be ≥1)
SCORE_WIDTH, 24, score counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
frame_tick  input  1  one-cycle pulse, once per frame
start  input  1  one-cycle pulse; starts or restarts a game
doodle_valid  input  1  doodle_y is valid this cycle
doodle_y  input  WIDTH  signed doodle world Y
view_bottom  output  WIDTH  registered world Y of the bottom screen row
view_top  output  WIDTH  view_bottom + SCREEN_HEIGHT - 1 (combinational from register)
scroll_delta  output  clog2(MAX_STEP+1)  advance applied on the last update, 0 otherwise
new_view  output  1  one-cycle pulse when view_bottom changed
fell  output  1  one-cycle pulse on fall detection
game_over  output  1  level, high in OVER
score  output  SCORE_WIDTH  saturating max height (equals view_bottom, clipped)
busy_scroll  output  1  high in SCROLL state

Behaviour:
- Reset (async assert; release synchronous to clk): view_bottom=0, score=0, scroll_delta=0, new_view=0, fell=0, game_over=0, state=IDLE.
- States:
  - IDLE: waits for start. On start, view_bottom and score stay 0; go to TRACK.
  - TRACK: normal play.
  - SCROLL: catching up after a jump; busy_scroll=1.
  - OVER: game_over=1; all registers hold. On start: view_bottom=0, score=0, go to TRACK.
- start in TRACK/SCROLL restarts: clear view_bottom and score, go to TRACK. start has priority over a same-cycle frame_tick.
- Update happens only in TRACK/SCROLL on a cycle with frame_tick && doodle_valid. Ticks without valid are ignored (no pulses, state held). Non-tick cycles: new_view=0, fell=0, scroll_delta=0.
- On update, signed compare of doodle_y against zero-extended view_bottom:
  - if doodle_y < view_bottom: fell=1 for one cycle, go to OVER, no scroll (fall beats scroll). doodle_y == view_bottom is not a fall.
  - else gap = doodle_y − (view_bottom + SCROLL_MARGIN). If gap > 0: step = min(gap, MAX_STEP); view_bottom += step; scroll_delta = step; new_view=1 for one cycle. Next state is SCROLL if gap > MAX_STEP, else TRACK. gap ≤ 0 (including doodle exactly on the scroll line): no change, go to TRACK.
- Latency: outputs reflect an update on the clock edge after the tick cycle (registered, 1 cycle). Pulses last exactly one cycle.
- Saturation: VIEW_MAX = 2^(WIDTH−1) − SCREEN_HEIGHT. The step is clipped so view_bottom ≤ VIEW_MAX. If the clipped step is 0: no new_view and scroll_delta=0.
- score = min(view_bottom, 2^SCORE_WIDTH − 1), updated with view_bottom. It never decreases except on start.
- Async reset mid-scroll returns to IDLE immediately, all outputs at reset values.

Test Plan:
- Reset, start, tick with doodle_y=100 → TRACK, view_bottom=0, no new_view/fell, view_top=699.
- doodle_y=352, tick → next cycle view_bottom=2, scroll_delta=2, new_view one cycle, score=2, state TRACK.
- doodle_y=370 held from view_bottom=0, ticks → view_bottom 4,8,12,16,20, busy_scroll high until final tick; last step 4 → TRACK; an exact-line tick (doodle 370 at vb 20) gives no new_view.
- view_bottom=20, doodle_y=19, tick → fell pulse, game_over=1, view_bottom held at 20; further ticks ignored; start → view_bottom=0, score=0, TRACK.
- Same-cycle start and tick with doodle_y=1000 in TRACK → restart wins, view_bottom=0, no new_view; tick without doodle_valid → nothing changes.
- WIDTH=12, SCORE_WIDTH=8, view_bottom=VIEW_MAX−2 (1346), large doodle_y → step 2, then 0 with no new_view; score saturates at 255; async reset during SCROLL → IDLE, all zeros.
